// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use stall, forwarding, memory freeze and watchdog control for the 5-stage pipeline
// Optional stall-cycle counter enabled by HZD_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] id_ra,
    input  logic [3:0] id_rb,
    input  logic [3:0] id_rd,
    input  logic       id_use_a,
    input  logic       id_use_b,
    input  logic       id_use_d,
    input  logic [3:0] ex_rd,
    input  logic [3:0] mem_rd,
    input  logic [3:0] wb_rd,
    input  logic       ex_rf_e,
    input  logic       mem_rf_e,
    input  logic       wb_rf_e,
    input  logic       ex_load,
    input  logic       branched,
    input  logic       mem_req,
    input  logic       mem_ready,
    output logic       pc_e,
    output logic       ifid_e,
    output logic       nop_sel,
    output logic       ifid_flush,
    output logic       pipe_freeze,
    output logic [1:0] fwd_pa,
    output logic [1:0] fwd_pb,
    output logic [1:0] fwd_pd,
    output logic       mem_err
`ifdef HZD_PERF_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {RUN, LDSTALL, MEMWAIT, ERR} state_t;

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    state_t     state_q, state_d;
    logic [7:0] wd_q, wd_d;
    logic       mem_err_q, mem_err_d;
    logic       lu, mem_stall;

    // Youngest producer wins; R15 reads the PC so it always comes from the register file.
    function automatic logic [1:0] fwd_sel(input logic [3:0] rx, input logic use_x,
                                           input logic [3:0] e_rd, input logic e_we,
                                           input logic [3:0] m_rd, input logic m_we,
                                           input logic [3:0] w_rd, input logic w_we);
        logic [1:0] sel;
        sel = 2'b00;
        if (use_x && rx != 4'd15) begin
            if (rx == e_rd && e_we)      sel = 2'b01;
            else if (rx == m_rd && m_we) sel = 2'b10;
            else if (rx == w_rd && w_we) sel = 2'b11;
        end
        return sel;
    endfunction

    assign fwd_pa = reset ? fwd_sel(id_ra, id_use_a, ex_rd, ex_rf_e, mem_rd, mem_rf_e, wb_rd, wb_rf_e) : 2'b00;
    assign fwd_pb = reset ? fwd_sel(id_rb, id_use_b, ex_rd, ex_rf_e, mem_rd, mem_rf_e, wb_rd, wb_rf_e) : 2'b00;
    assign fwd_pd = reset ? fwd_sel(id_rd, id_use_d, ex_rd, ex_rf_e, mem_rd, mem_rf_e, wb_rd, wb_rf_e) : 2'b00;

    assign lu = ex_load && ex_rf_e &&
                ((id_use_a && id_ra == ex_rd && id_ra != 4'd15) ||
                 (id_use_b && id_rb == ex_rd && id_rb != 4'd15) ||
                 (id_use_d && id_rd == ex_rd && id_rd != 4'd15));

    assign mem_stall = mem_req && !mem_ready;
    assign mem_err   = mem_err_q;

    always_comb begin
        state_d     = state_q;
        wd_d        = wd_q;
        mem_err_d   = mem_err_q;
        pc_e        = 1'b1;
        ifid_e      = 1'b1;
        nop_sel     = 1'b0;
        ifid_flush  = 1'b0;
        pipe_freeze = 1'b0;
        case (state_q)
            RUN, LDSTALL: begin
                state_d = RUN;
                if (mem_stall) begin
                    pipe_freeze = 1'b1;
                    pc_e        = 1'b0;
                    ifid_e      = 1'b0;
                    state_d     = MEMWAIT;
                    wd_d        = 8'd0;
                end else if (branched) begin
                    ifid_flush = 1'b1;
                end else if (lu && state_q == RUN) begin
                    pc_e    = 1'b0;
                    ifid_e  = 1'b0;
                    nop_sel = 1'b1;
                    state_d = LDSTALL;
                end
            end
            MEMWAIT: begin
                pipe_freeze = 1'b1;
                pc_e        = 1'b0;
                ifid_e      = 1'b0;
                wd_d        = wd_q + 8'd1;
                if (mem_ready) begin
                    state_d = RUN;
                end else if (wd_d == TIMEOUT) begin
                    state_d   = ERR;
                    mem_err_d = 1'b1;
                end
            end
            default: begin
                pipe_freeze = 1'b1;
                pc_e        = 1'b0;
                ifid_e      = 1'b0;
                mem_err_d   = 1'b1;
            end
        endcase
        // Reset holds the front end and bubbles ID/EX regardless of state.
        if (!reset) begin
            pc_e        = 1'b0;
            ifid_e      = 1'b0;
            nop_sel     = 1'b1;
            ifid_flush  = 1'b0;
            pipe_freeze = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RUN;
            wd_q      <= 8'd0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wd_q      <= wd_d;
            mem_err_q <= mem_err_d;
        end
    end

`ifdef HZD_PERF_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= 16'd0;
        end else if (!pc_e && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] id_ra, id_rb, id_rd, ex_rd, mem_rd, wb_rd;
    logic       id_use_a, id_use_b, id_use_d;
    logic       ex_rf_e, mem_rf_e, wb_rf_e, ex_load, branched, mem_req, mem_ready;
    logic       pc_e, ifid_e, nop_sel, ifid_flush, pipe_freeze, mem_err;
    logic [1:0] fwd_pa, fwd_pb, fwd_pd;
`ifdef HZD_PERF_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .id_ra(id_ra), .id_rb(id_rb), .id_rd(id_rd),
        .id_use_a(id_use_a), .id_use_b(id_use_b), .id_use_d(id_use_d),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_rf_e(ex_rf_e), .mem_rf_e(mem_rf_e), .wb_rf_e(wb_rf_e),
        .ex_load(ex_load), .branched(branched),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_e(pc_e), .ifid_e(ifid_e), .nop_sel(nop_sel), .ifid_flush(ifid_flush),
        .pipe_freeze(pipe_freeze),
        .fwd_pa(fwd_pa), .fwd_pb(fwd_pb), .fwd_pd(fwd_pd),
        .mem_err(mem_err)
`ifdef HZD_PERF_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs;
        id_ra = 0; id_rb = 0; id_rd = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
        id_use_a = 0; id_use_b = 0; id_use_d = 0;
        ex_rf_e = 0; mem_rf_e = 0; wb_rf_e = 0;
        ex_load = 0; branched = 0; mem_req = 0; mem_ready = 0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        clear_inputs();
        id_ra = 3; id_use_a = 1; ex_rd = 3; ex_rf_e = 1;
        #3;
        n_cmp++; if (pc_e !== 1'b0)        begin n_bad++; $display("FAIL rst_pc_e got %b want 0", pc_e); end
        n_cmp++; if (ifid_e !== 1'b0)      begin n_bad++; $display("FAIL rst_ifid_e got %b want 0", ifid_e); end
        n_cmp++; if (nop_sel !== 1'b1)     begin n_bad++; $display("FAIL rst_nop_sel got %b want 1", nop_sel); end
        n_cmp++; if (pipe_freeze !== 1'b0) begin n_bad++; $display("FAIL rst_freeze got %b want 0", pipe_freeze); end
        n_cmp++; if (fwd_pa !== 2'b00)     begin n_bad++; $display("FAIL rst_fwd_pa got %b want 00", fwd_pa); end
        n_cmp++; if (mem_err !== 1'b0)     begin n_bad++; $display("FAIL rst_mem_err got %b want 0", mem_err); end
        tick();
        clear_inputs();
        reset = 1'b1;
        #1;
        n_cmp++; if (pc_e !== 1'b1 || ifid_e !== 1'b1 || nop_sel !== 1'b0)
            begin n_bad++; $display("FAIL run_idle got pc_e=%b ifid_e=%b nop=%b want 1 1 0", pc_e, ifid_e, nop_sel); end
    endtask

    task automatic test_forwarding;
        tick();
        ex_rd = 3; mem_rd = 3; wb_rd = 3; ex_rf_e = 1; mem_rf_e = 1; wb_rf_e = 1;
        id_ra = 3; id_use_a = 1; id_rb = 3; id_use_b = 0; id_rd = 3; id_use_d = 1;
        #1;
        n_cmp++; if (fwd_pa !== 2'b01) begin n_bad++; $display("FAIL fwd_ex got %b want 01", fwd_pa); end
        n_cmp++; if (fwd_pb !== 2'b00) begin n_bad++; $display("FAIL fwd_unused got %b want 00", fwd_pb); end
        n_cmp++; if (fwd_pd !== 2'b01) begin n_bad++; $display("FAIL fwd_pd_ex got %b want 01", fwd_pd); end
        ex_rf_e = 0; #1;
        n_cmp++; if (fwd_pa !== 2'b10) begin n_bad++; $display("FAIL fwd_mem got %b want 10", fwd_pa); end
        mem_rf_e = 0; #1;
        n_cmp++; if (fwd_pa !== 2'b11) begin n_bad++; $display("FAIL fwd_wb got %b want 11", fwd_pa); end
        ex_rd = 15; mem_rd = 15; wb_rd = 15; ex_rf_e = 1; mem_rf_e = 1; id_ra = 15; #1;
        n_cmp++; if (fwd_pa !== 2'b00) begin n_bad++; $display("FAIL fwd_r15 got %b want 00", fwd_pa); end
        clear_inputs();
    endtask

    task automatic test_load_use;
        tick();
        ex_load = 1; ex_rf_e = 1; ex_rd = 5; id_rb = 5; id_use_b = 1;
        #1;
        n_cmp++; if (pc_e !== 1'b0 || ifid_e !== 1'b0 || nop_sel !== 1'b1)
            begin n_bad++; $display("FAIL lu_stall got pc_e=%b ifid_e=%b nop=%b want 0 0 1", pc_e, ifid_e, nop_sel); end
        tick();
        ex_load = 0; ex_rf_e = 0; ex_rd = 0; mem_rd = 5; mem_rf_e = 1;
        #1;
        n_cmp++; if (pc_e !== 1'b1 || ifid_e !== 1'b1 || nop_sel !== 1'b0)
            begin n_bad++; $display("FAIL lu_ldstall got pc_e=%b ifid_e=%b nop=%b want 1 1 0", pc_e, ifid_e, nop_sel); end
        n_cmp++; if (fwd_pb !== 2'b10) begin n_bad++; $display("FAIL lu_fwd got %b want 10", fwd_pb); end
        tick();
        mem_rf_e = 0; ex_load = 1; ex_rf_e = 1; ex_rd = 5;
        #1;
        n_cmp++; if (nop_sel !== 1'b1) begin n_bad++; $display("FAIL lu_back_in_run got nop=%b want 1", nop_sel); end
        clear_inputs();
        tick();
    endtask

    task automatic test_branch_lu;
        tick();
        branched = 1; ex_load = 1; ex_rf_e = 1; ex_rd = 7; id_ra = 7; id_use_a = 1;
        #1;
        n_cmp++; if (ifid_flush !== 1'b1) begin n_bad++; $display("FAIL br_flush got %b want 1", ifid_flush); end
        n_cmp++; if (pc_e !== 1'b1)       begin n_bad++; $display("FAIL br_pc_e got %b want 1", pc_e); end
        n_cmp++; if (nop_sel !== 1'b0)    begin n_bad++; $display("FAIL br_nop got %b want 0", nop_sel); end
        tick();
        branched = 0;
        #1;
        n_cmp++; if (nop_sel !== 1'b1 || ifid_flush !== 1'b0)
            begin n_bad++; $display("FAIL br_stays_run got nop=%b flush=%b want 1 0", nop_sel, ifid_flush); end
        clear_inputs();
        tick();
    endtask

    task automatic test_mem_wait;
        tick();
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (pipe_freeze !== 1'b1 || pc_e !== 1'b0)
                begin n_bad++; $display("FAIL mw_freeze_%0d got frz=%b pc_e=%b want 1 0", i, pipe_freeze, pc_e); end
            tick();
        end
        mem_ready = 1; branched = 1;
        #1;
        n_cmp++; if (pipe_freeze !== 1'b1 || ifid_flush !== 1'b0)
            begin n_bad++; $display("FAIL mw_ready_cycle got frz=%b flush=%b want 1 0", pipe_freeze, ifid_flush); end
        tick();
        clear_inputs();
        #1;
        n_cmp++; if (pipe_freeze !== 1'b0 || pc_e !== 1'b1)
            begin n_bad++; $display("FAIL mw_release got frz=%b pc_e=%b want 0 1", pipe_freeze, pc_e); end
    endtask

    task automatic test_watchdog;
        tick();
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++; if (mem_err !== 1'b0) begin n_bad++; $display("FAIL wd_early_%0d got %b want 0", i, mem_err); end
            tick();
        end
        n_cmp++; if (mem_err !== 1'b1 || pc_e !== 1'b0)
            begin n_bad++; $display("FAIL wd_err got err=%b pc_e=%b want 1 0", mem_err, pc_e); end
        clear_inputs();
        tick();
        tick();
        n_cmp++; if (mem_err !== 1'b1 || pipe_freeze !== 1'b1)
            begin n_bad++; $display("FAIL wd_sticky got err=%b frz=%b want 1 1", mem_err, pipe_freeze); end
        reset = 1'b0;
        #1;
        n_cmp++; if (mem_err !== 1'b0 || pc_e !== 1'b0 || nop_sel !== 1'b1)
            begin n_bad++; $display("FAIL wd_reset got err=%b pc_e=%b nop=%b want 0 0 1", mem_err, pc_e, nop_sel); end
        reset = 1'b1;
        #1;
        n_cmp++; if (pc_e !== 1'b1 || pipe_freeze !== 1'b0)
            begin n_bad++; $display("FAIL wd_after_reset got pc_e=%b frz=%b want 1 0", pc_e, pipe_freeze); end
    endtask

`ifdef HZD_PERF_CNT_EN
    task automatic test_perf;
        tick();
        reset = 1'b0;
        #1;
        n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL perf_reset got %0d want 0", stall_cnt); end
        reset = 1'b1;
        ex_load = 1; ex_rf_e = 1; ex_rd = 2; id_ra = 2; id_use_a = 1;
        tick();
        clear_inputs();
        tick();
        mem_req = 1;
        tick(); tick(); tick();
        mem_ready = 1;
        tick();
        clear_inputs();
        #1;
        n_cmp++; if (stall_cnt !== 16'd5) begin n_bad++; $display("FAIL perf_count got %0d want 5", stall_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch_lu();
        test_mem_wait();
        test_watchdog();
`ifdef HZD_PERF_CNT_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage ARM-subset pipeline. It sits beside the ID stage and drives the datapath control points:
- PC enable and IF/ID enable;
- the control-unit NOP multiplexer select;
- the IF/ID flush;
- the PA/PB/PD operand-forwarding multiplexer selects.

It detects load-use hazards, resolves forwarding, and freezes the pipeline during multi-cycle data-memory accesses. A watchdog detects memory that never responds.

## Interface
Parameters:
- MEM_TIMEOUT, 15: maximum MEMWAIT cycles before watchdog error (1..255).

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_ra, id_rb, id_rd  in  4 each  ID-stage source register numbers (instr[3:0], [19:16], [15:12]).
- id_use_a, id_use_b, id_use_d  in  1 each  ID instruction actually reads that operand.
- ex_rd, mem_rd, wb_rd  in  4 each  destination register in EX, MEM, WB.
- ex_rf_e, mem_rf_e, wb_rf_e  in  1 each  destination write enable per stage.
- ex_load  in  1  EX instruction is a load.
- branched  in  1  condition handler resolved a taken branch.
- mem_req  in  1  MEM stage has an active data-memory access.
- mem_ready  in  1  data memory completes access this cycle.
- pc_e  out  1  PC load enable.
- ifid_e  out  1  IF/ID load enable.
- nop_sel  out  1  1 = control mux outputs all-zero (bubble into ID/EX).
- ifid_flush  out  1  clears IF/ID to NOP at next edge.
- pipe_freeze  out  1  holds ID/EX, EX/MEM, MEM/WB.
- fwd_pa, fwd_pb, fwd_pd  out  2 each  00 RF, 01 EX, 10 MEM, 11 WB.
- mem_err  out  1  sticky watchdog error.

## Operation
FSM states: RUN, LDSTALL, MEMWAIT, ERR.

Forwarding (combinational, independent of state) for each operand x in {a,b,d}:
- Default fwd_px = 00.
- If id_use_x and id_rx == ex_rd and ex_rf_e: 01.
- Else if id_rx == mem_rd and mem_rf_e: 10.
- Else if id_rx == wb_rd and wb_rf_e: 11.
- Youngest stage wins. R15 (PC) is never forwarded: returns 00.

Load-use hazard (lu): ex_load & ex_rf_e & (any id_use_x with id_rx == ex_rd, rx ≠ 15).

Output decode and transitions, in priority order from RUN:
1. mem_req & ~mem_ready:
   - pipe_freeze=1, pc_e=0, ifid_e=0.
   - Next MEMWAIT; watchdog loads 0.
2. branched:
   - ifid_flush=1, pc_e=1.
   - Stay RUN.
   - A simultaneous lu is dropped: the flushed instruction never issues.
3. lu:
   - pc_e=0, ifid_e=0, nop_sel=1.
   - Next LDSTALL.
4. Otherwise: pc_e=1, ifid_e=1, all others 0.

LDSTALL:
- All enables 1, nop_sel=0; exactly one bubble has been inserted.
- Next RUN.
- mem_req & ~mem_ready here takes priority and goes to MEMWAIT.

MEMWAIT:
- pipe_freeze=1, pc_e=0, ifid_e=0, nop_sel=0.
- Watchdog increments each cycle.
- mem_ready: next RUN, freeze released in that cycle.
- Watchdog == MEM_TIMEOUT without mem_ready: next ERR.
- branched is ignored while frozen.

ERR:
- pc_e=0, ifid_e=0, pipe_freeze=1, mem_err=1.
- Held until reset.

Reset (asynchronous, any state, including mid-stall or mid-MEMWAIT):
- State goes to RUN, watchdog to 0, mem_err to 0.
- Decoded outputs while reset is low: pc_e=0, ifid_e=0, nop_sel=1, ifid_flush=0, pipe_freeze=0, fwd_*=00.

## Timing
- Forwarding selects and all control outputs are combinational from the current state and inputs; they are valid before the next rising edge.
- State, watchdog and mem_err are registered on the rising clk edge.
- Load-use costs exactly 1 stall cycle; a taken branch costs 1 flush cycle.
- A memory access with mem_ready in cycle k of MEMWAIT freezes for k+1 cycles total, counting the entry cycle.
- MEMWAIT entry with mem_ready never asserting reaches ERR after MEM_TIMEOUT+1 cycles.

## Configuration
- HZD_PERF_CNT_EN defined:
  - Adds output stall_cnt (16 bits), a saturating count of cycles with pc_e=0 outside reset.
  - stall_cnt is reset to 0 by reset.
  - It holds at 16'hFFFF once saturated.
- HZD_PERF_CNT_EN undefined: the port and counter are absent.

## Test plan
- Forwarding priority: ex_rd=mem_rd=wb_rd=3, all rf_e=1, id_ra=3, id_use_a=1, ex_load=0 -> fwd_pa=01. Drop ex_rf_e -> 10. Drop mem_rf_e -> 11. id_ra=15 -> 00.
- Load-use: ex_load=1, ex_rd=5, id_rb=5, id_use_b=1 -> one cycle with pc_e=0, ifid_e=0, nop_sel=1, then LDSTALL with pc_e=1; the third cycle is back in RUN.
- Branch plus load-use in the same cycle: ifid_flush=1, pc_e=1, nop_sel=0, state stays RUN.
- Memory wait: mem_req=1, mem_ready low for 3 cycles then high -> pipe_freeze high 4 cycles, then released.
- Watchdog with MEM_TIMEOUT=4: mem_ready held low -> mem_err=1 after 5 cycles and sticky. Assert reset low mid-ERR -> mem_err=0, state RUN, pc_e=0 while reset is low.
- With HZD_PERF_CNT_EN: 1 load-use stall plus a 4-cycle freeze -> stall_cnt=5.
